// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit for the E stage.
// The result is computed when the operation is accepted and held in the pending
// registers. It is committed to HI/LO after a fixed countdown, so HI/LO only change
// where the architecture says they do.
module muldiv_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        we_hi,
   input  logic        we_lo,
   input  logic [31:0] wdata,
   input  logic        md_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef enum logic {StIdle, StBusy} state_t;

   state_t            state;
   logic [CntW-1:0]   cnt;
   logic [31:0]       pend_hi;
   logic [31:0]       pend_lo;
   logic              pend_wr;

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic signed [31:0] sdivisor;
   logic        [31:0] udivisor;
   logic signed [31:0] squot;
   logic signed [31:0] srem;
   logic        [31:0] uquot;
   logic        [31:0] urem;
   logic        [63:0] result;
   logic               div_zero;

   // Operand datapath; divisors are forced to 1 where the true division is undefined
   // (zero divisor) or overflows (-2^31 / -1, whose wrapped quotient is the dividend).
   always_comb begin
      sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      uprod    = {32'd0, a} * {32'd0, b};
      div_zero = (b == 32'd0);
      sdivisor = (div_zero || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'sd1 : $signed(b);
      udivisor = div_zero ? 32'd1 : b;
      squot    = $signed(a) / sdivisor;
      srem     = $signed(a) % sdivisor;
      uquot    = a / udivisor;
      urem     = a % udivisor;
      unique case (op)
         2'b00:   result = sprod;
         2'b01:   result = uprod;
         2'b10:   result = {srem, squot};
         default: result = {urem, uquot};
      endcase
   end

   // Control FSM with HI/LO and pending-result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StIdle;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  pend_hi <= result[63:32];
                  pend_lo <= result[31:0];
                  // A divide by zero still occupies the unit but commits nothing
                  pend_wr <= !(op[1] && div_zero);
                  cnt     <= op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                  state   <= StBusy;
               end else begin
                  if (we_hi) hi <= wdata;
                  if (we_lo) lo <= wdata;
               end
            end
            default: begin
               if (cnt == CntW'(1)) begin
                  if (pend_wr) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  cnt   <= '0;
                  state <= StIdle;
               end else begin
                  cnt <= cnt - CntW'(1);
               end
            end
         endcase
      end
   end

   // Status outputs; stall also covers the cycle in which the operation is issued.
   always_comb begin
      busy  = (state == StBusy);
      stall = md_d & (start | busy);
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO pairs are queued when an
// operation is issued and checked when the unit drops busy.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wdata;
   logic        md_d;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wdata (wdata),
      .md_d  (md_d),
      .busy  (busy),
      .stall (stall),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Issue one operation at a negedge (cycle 0) and follow it to cycle n+1.
   // disturb: mthi alongside start, then start/mtlo pulses in busy cycle 3.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] opa,
                         input logic [31:0] opb, input logic [63:0] expv, input int n,
                         input logic md, input bit disturb);
      logic [63:0] popped;
      @(negedge clk);
      start = 1'b1; op = o; a = opa; b = opb; md_d = md;
      we_hi = disturb; wdata = 32'hDEAD_BEEF;
      exp_q.push_back(expv);
      #1;
      chk({name, " busy c0"}, {63'd0, busy}, 64'd0);
      chk({name, " stall c0"}, {63'd0, stall}, {63'd0, md});
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
         a = $urandom; b = $urandom;
         if (disturb && i == 3) begin
            start = 1'b1; op = 2'b00; we_lo = 1'b1;
         end
         #1;
         chk($sformatf("%s busy c%0d", name, i), {63'd0, busy}, 64'd1);
         chk($sformatf("%s stall c%0d", name, i), {63'd0, stall}, {63'd0, md});
      end
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      #1;
      chk({name, " busy end"}, {63'd0, busy}, 64'd0);
      chk({name, " stall end"}, {63'd0, stall}, 64'd0);
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL %s scoreboard: observed empty queue expected entry", name);
      end
      if (exp_q.size() > 0) begin
         popped = exp_q.pop_front();
         chk({name, " hilo"}, {hi, lo}, popped);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      we_hi = 1'b0; we_lo = 1'b0; wdata = '0; md_d = 1'b0;
      #2;
      chk("reset hilo", {hi, lo}, 64'd0);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5, 1'b1, 1'b0);
      run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 5, 1'b0, 1'b0);
      run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b1, 1'b0);
      run_op("divu", 2'b11, 32'd7, 32'd2, {32'd1, 32'd3}, 10, 1'b0, 1'b0);

      // mthi then mtlo on consecutive idle cycles
      @(negedge clk);
      we_hi = 1'b1; wdata = 32'h1234_5678;
      #1;
      chk("mthi before edge", {hi, lo}, {32'd1, 32'd3});
      @(negedge clk);
      we_hi = 1'b0; we_lo = 1'b1; wdata = 32'h9ABC_DEF0;
      #1;
      chk("mthi after edge", {hi, lo}, {32'h1234_5678, 32'd3});
      @(negedge clk);
      we_lo = 1'b0;
      #1;
      chk("mtlo after edge", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

      run_op("divzero", 2'b10, 32'd55, 32'd0, {32'h1234_5678, 32'h9ABC_DEF0}, 10, 1'b0, 1'b0);
      // 100 / 7 = 14 rem 2; concurrent mthi and busy-time pulses must not disturb it
      run_op("disturbed", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 1'b1, 1'b0 | 1'b1);

      // Reset in busy cycle 4 of a div
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4; md_d = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      #1;
      chk("rst mid busy", {63'd0, busy}, 64'd0);
      chk("rst mid stall", {63'd0, stall}, 64'd1);
      chk("rst mid hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0; md_d = 1'b0;
      for (int i = 6; i <= 12; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post rst busy c%0d", i), {63'd0, busy}, 64'd0);
         chk($sformatf("post rst hilo c%0d", i), {hi, lo}, 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
